game_state_ctrl: RTL
====================

// Module: game_state_ctrl
// PURPOSE
// Game supervisor downstream of the bird controller. Consumes bird height (V_pos, larger = higher) and the
// current pipe position/gap, and detects ground/ceiling/pipe collisions. Runs the IDLE/PLAY/DEAD/OVER state
// machine, gates flap presses into one-cycle flap pulses for the bird controller, and keeps score/high score.
// PARAMETERS
// BIRD_X   100  left edge of bird sprite, screen px (fixed column)
// BIRD_W   16   bird sprite width, px
// BIRD_H   12   bird sprite height, px
// PIPE_W   40   pipe width, px
// GROUND_Y 20   bird dies when bird_v <= GROUND_Y
// CEIL_Y   460  bird dies when bird_v + BIRD_H >= CEIL_Y
// DEAD_MS  500  ticks spent in DEAD before OVER
// SCORE_MAX 999 score saturation value
// PORTS
// clk        in  1   system clock
// rst        in  1   synchronous reset, active-high
// tick       in  1   1 ms game-tick enable, one clk wide
// flap_btn   in  1   debounced flap button level
// bird_v     in  9   bird height (bottom edge), px above screen bottom
// pipe_x     in  10  pipe left edge, screen px, unsigned; wraps to right edge on respawn
// gap_lo     in  9   bottom of pipe gap, px
// gap_hi     in  9   top of pipe gap, px (gap_hi > gap_lo)
// state      out 2   0 IDLE, 1 PLAY, 2 DEAD, 3 OVER
// flap_out   out 1   one-clk flap pulse to bird controller
// freeze     out 1   1 = bird/pipe motion halted (all states except PLAY)
// collide    out 1   one-clk pulse on the tick a collision is detected
// score      out 10  pipes passed this game, binary, saturating
// high_score out 10  best score since rst
// BEHAVIOUR
// - Reset: state=IDLE, flap_out=0, freeze=1, collide=0, score=0, high_score=0, pend=0, dead_cnt=0, passed=0.
// - Flap edge detect every clk: rise = flap_btn & ~flap_q. Rise sets pend; pend is cleared on every tick.
// - Evaluation only in cycles with tick=1; all outputs are registered, so they update 1 clk after the tick edge.
// - IDLE: freeze=1. tick & pend -> PLAY, flap_out=1, score=0.
// - PLAY: freeze=0. Per tick:
//   ground hit = bird_v <= GROUND_Y; ceiling hit = bird_v + BIRD_H >= CEIL_Y (10-bit sum).
//   h_overlap = (pipe_x < BIRD_X+BIRD_W) && (pipe_x+PIPE_W > BIRD_X), 11-bit sums, no wrap.
//   pipe hit = h_overlap && (bird_v < gap_lo || bird_v+BIRD_H > gap_hi).
//   Any hit -> DEAD, collide=1, dead_cnt=0; no flap_out and no score on that tick (collision wins).
//   Else pend -> flap_out=1.
//   passed_now = (pipe_x+PIPE_W <= BIRD_X). On rising edge of passed_now (registered passed) -> score+1,
//   saturating at SCORE_MAX. Pipe wrap drops passed_now to 0, which re-arms scoring; one point per pipe.
// - DEAD: freeze=1; flaps ignored. dead_cnt increments per tick; at dead_cnt==DEAD_MS-1 -> OVER.
//   On entry, high_score <= max(high_score, score), same cycle as collide.
// - OVER: freeze=1; score held. tick & pend -> IDLE (score cleared on the next IDLE->PLAY).
// - flap_out and collide are never high together; each is high for exactly one clk.
// - rst mid-game returns to IDLE next clk, clearing high_score too; no flap_out issued.
// - Button held across states produces no further rise; a new press is needed.
// TESTING
// - rst; press flap, tick -> state=PLAY, exactly one flap_out pulse, score=0, freeze=0.
// - PLAY, bird_v=20 on tick -> collide pulse, state=DEAD, no flap_out even with pend=1; after 500 ticks state=OVER.
// - pipe_x sweeps 200->40 with bird_v inside gap 150..250 -> no collide; score 0->1 at pipe_x=60; wrap to 639 and repeat -> 2.
// - bird_v=240, gap 150..250, pipe_x=110 -> pipe hit (240+12>250), DEAD; high_score=score on that cycle.
// - Score preloaded to 999, another pass -> stays 999; hit and pass on the same tick -> score unchanged.
// - rst asserted in PLAY with score=5 -> next clk state=IDLE, score=0, high_score=0, freeze=1.

Source files
------------

// File: rtl/game_state_ctrl.sv
// -----------------------------------------------------------------------------
// game_state_ctrl
// Game supervisor that sits after the bird controller. It watches the bird
// height and the current pipe, detects ground / ceiling / pipe collisions, runs
// the IDLE -> PLAY -> DEAD -> OVER game flow, turns flap presses into one-clock
// flap pulses and keeps the current score and the best score since reset.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   tick       in   1 ms game-tick enable, one clk wide
//   flap_btn   in   debounced flap button level
//   bird_v     in   [8:0] bird bottom edge, px above screen bottom
//   pipe_x     in   [9:0] pipe left edge, screen px
//   gap_lo     in   [8:0] bottom of the pipe gap, px
//   gap_hi     in   [8:0] top of the pipe gap, px
//   state      out  [1:0] 0 IDLE, 1 PLAY, 2 DEAD, 3 OVER
//   flap_out   out  one-clk flap pulse to the bird controller
//   freeze     out  1 = bird/pipe motion halted (every state except PLAY)
//   collide    out  one-clk pulse on the tick a collision is detected
//   score      out  [9:0] pipes passed this game, saturating
//   high_score out  [9:0] best score since reset
// -----------------------------------------------------------------------------
module game_state_ctrl #(
  parameter int BIRD_X    = 100,
  parameter int BIRD_W    = 16,
  parameter int BIRD_H    = 12,
  parameter int PIPE_W    = 40,
  parameter int GROUND_Y  = 20,
  parameter int CEIL_Y    = 460,
  parameter int DEAD_MS   = 500,
  parameter int SCORE_MAX = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       flap_btn,
  input  logic [8:0] bird_v,
  input  logic [9:0] pipe_x,
  input  logic [8:0] gap_lo,
  input  logic [8:0] gap_hi,
  output logic [1:0] state,
  output logic       flap_out,
  output logic       freeze,
  output logic       collide,
  output logic [9:0] score,
  output logic [9:0] high_score
);

  localparam int DC_W = $clog2(DEAD_MS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DEAD = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic              flap_q_reg;
  logic              pend_reg, pend_next;
  logic              passed_reg, passed_next;
  logic [DC_W-1:0]   dead_cnt_reg, dead_cnt_next;
  logic [9:0]        score_reg, score_next;
  logic [9:0]        high_reg, high_next;
  logic              flap_out_reg, flap_out_next;
  logic              collide_reg, collide_next;
  logic              freeze_reg, freeze_next;

  // Geometry, widened so none of the sums can wrap.
  logic [9:0]  bird_bot, bird_top;
  logic [10:0] pipe_l, pipe_r;
  logic        rise, ground_hit, ceil_hit, h_overlap, pipe_hit, any_hit, passed_now;

  assign rise       = flap_btn & ~flap_q_reg;
  assign bird_bot   = {1'b0, bird_v};
  assign bird_top   = bird_bot + 10'(BIRD_H);
  assign pipe_l     = {1'b0, pipe_x};
  assign pipe_r     = pipe_l + 11'(PIPE_W);
  assign ground_hit = bird_bot <= 10'(GROUND_Y);
  assign ceil_hit   = bird_top >= 10'(CEIL_Y);
  assign h_overlap  = (pipe_l < 11'(BIRD_X + BIRD_W)) && (pipe_r > 11'(BIRD_X));
  assign pipe_hit   = h_overlap && ((bird_v < gap_lo) || (bird_top > {1'b0, gap_hi}));
  assign any_hit    = ground_hit | ceil_hit | pipe_hit;
  // Pipe fully left of the bird. A respawn at the right edge clears this,
  // which re-arms scoring for the next pipe.
  assign passed_now = pipe_r <= 11'(BIRD_X);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      flap_q_reg   <= 1'b0;
      pend_reg     <= 1'b0;
      passed_reg   <= 1'b0;
      dead_cnt_reg <= '0;
      score_reg    <= '0;
      high_reg     <= '0;
      flap_out_reg <= 1'b0;
      collide_reg  <= 1'b0;
      freeze_reg   <= 1'b1;
    end else begin
      state_reg    <= state_next;
      flap_q_reg   <= flap_btn;
      pend_reg     <= pend_next;
      passed_reg   <= passed_next;
      dead_cnt_reg <= dead_cnt_next;
      score_reg    <= score_next;
      high_reg     <= high_next;
      flap_out_reg <= flap_out_next;
      collide_reg  <= collide_next;
      freeze_reg   <= freeze_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    // A press arriving on the tick cycle itself is kept for the next tick.
    pend_next     = rise | (pend_reg & ~tick);
    passed_next   = tick ? passed_now : passed_reg;
    dead_cnt_next = dead_cnt_reg;
    score_next    = score_reg;
    high_next     = high_reg;
    flap_out_next = 1'b0;
    collide_next  = 1'b0;

    if (tick) begin
      unique case (state_reg)
        S_IDLE: begin
          if (pend_reg) begin
            state_next    = S_PLAY;
            flap_out_next = 1'b1;
            score_next    = '0;
          end
        end
        S_PLAY: begin
          if (any_hit) begin
            // Collision wins over both flap and scoring on the same tick.
            state_next    = S_DEAD;
            collide_next  = 1'b1;
            dead_cnt_next = '0;
            if (score_reg > high_reg) high_next = score_reg;
          end else begin
            if (pend_reg) flap_out_next = 1'b1;
            if (passed_now && !passed_reg && (score_reg != 10'(SCORE_MAX)))
              score_next = score_reg + 10'd1;
          end
        end
        S_DEAD: begin
          if (dead_cnt_reg == DC_W'(DEAD_MS - 1)) state_next = S_OVER;
          else dead_cnt_next = dead_cnt_reg + DC_W'(1);
        end
        S_OVER: begin
          if (pend_reg) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end

    freeze_next = (state_next != S_PLAY);
  end

  assign state      = state_reg;
  assign flap_out   = flap_out_reg;
  assign freeze     = freeze_reg;
  assign collide    = collide_reg;
  assign score      = score_reg;
  assign high_score = high_reg;

endmodule
